// File: rtl/mem_stage_cache.sv
// mem_stage_cache: ARM memory stage with a 2-way write-through, no-write-allocate data cache,
// SRAM request/ack backing port, MEM/WB register and upstream freeze.
module mem_stage_cache #(
    parameter int ADDR_BASE = 1024,
    parameter int SETS      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dst_in,
    output logic        wb_en_out,
    output logic        mem_read_en_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dst_out,
    output logic        freeze,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ack
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 29 - IW;
    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state_q, state_d;

    // Byte offset bits only matter as a borrow into the word address.
    logic [31:2] ea;
    assign ea = alu_result_in[31:2] - BASE[31:2] - 30'(alu_result_in[1:0] < BASE[1:0]);

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          word_sel;
    assign idx      = ea[IW+2:3];
    assign tag      = ea[31:IW+3];
    assign word_sel = ea[2];

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TW-1:0]        tag_q  [2][SETS];
    logic [63:0]          data_q [2][SETS];

    logic [1:0]  hit_w;
    logic        hit, hit_way, rd, wr, fill, wr_upd, rd_hit, victim;
    logic [63:0] line;
    logic [31:0] rd_word;

    assign hit_w[0] = valid_q[0][idx] && tag_q[0][idx] == tag;
    assign hit_w[1] = valid_q[1][idx] && tag_q[1][idx] == tag;
    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];
    assign victim   = lru_q[idx];
    assign rd       = mem_read_en_in;
    assign wr       = mem_write_en_in && !mem_read_en_in;
    assign fill     = state_q == RD_WAIT && sram_ack;
    assign wr_upd   = state_q == WR_WAIT && sram_ack && hit;
    assign rd_hit   = state_q == IDLE && rd && hit;
    assign line     = (state_q == RD_WAIT) ? sram_rdata : data_q[hit_way][idx];
    assign rd_word  = word_sel ? line[63:32] : line[31:0];

    assign sram_req   = state_q != IDLE;
    assign sram_we    = state_q == WR_WAIT;
    assign sram_addr  = {ea[31:3], sram_we && ea[2], 2'b00};
    assign sram_wdata = val_rm_in;

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        case (state_q)
            IDLE: begin
                freeze  = (rd && !hit) || wr;
                state_d = (rd && !hit) ? RD_WAIT : wr ? WR_WAIT : IDLE;
            end
            RD_WAIT, WR_WAIT: begin
                freeze  = !sram_ack;
                state_d = sram_ack ? IDLE : state_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            lru_q           <= '0;
            wb_en_out       <= 1'b0;
            mem_read_en_out <= 1'b0;
            alu_result_out  <= '0;
            mem_data_out    <= '0;
            dst_out         <= '0;
        end else begin
            state_q         <= state_d;
            if (fill) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= ~victim;
            end
            if (rd_hit || wr_upd)
                lru_q[idx] <= ~hit_way;
            wb_en_out       <= !freeze && wb_en_in;
            mem_read_en_out <= !freeze && mem_read_en_in;
            if (!freeze) begin
                alu_result_out <= alu_result_in;
                mem_data_out   <= rd_word;
                dst_out        <= dst_in;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[victim][idx] <= sram_rdata;
            tag_q[victim][idx]  <= tag;
        end
        if (wr_upd)
            data_q[hit_way][idx][{word_sel, 5'd0} +: 32] <= val_rm_in;
    end
endmodule
